packet_rr_scheduler: RTL and testbench
======================================

Name: packet_rr_scheduler

Overview:
Round-robin scheduler that shares one increment datapath (data + 1, packet register) among NUM_REQ requesters. Each requester offers an 8-bit byte over a valid/ready handshake. The scheduler grants one requester per accepted transfer, holds the incremented result in a single output packet register with its source index, and presents it downstream over valid/ready. It sits between the per-channel producers and the single packet consumer.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
WIDTH, PKG_WIDTH (16), width of the transfer counter
SRC_W, $clog2(NUM_REQ), derived localparam, width of source index

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  when low, no new grants; a held output still drains
req_valid  in  NUM_REQ  per-requester data valid
req_data  in  NUM_REQ*8  requester i data at [8*i+7:8*i]
req_ready  out  NUM_REQ  one-hot grant/accept, combinational
out_valid  out  1  output packet valid (packet_reg.valid)
out_data  out  8  incremented data (packet_reg.data)
out_src  out  SRC_W  index of requester that produced out_data
out_ready  in  1  downstream accept
xfer_count  out  WIDTH  number of accepted input transfers, wraps

Behaviour:
- Reset (reset=1 at posedge clk): packet_reg <= '0 (out_valid=0, out_data=0), out_src=0, xfer_count=0, rr pointer=0, state=IDLE. Reset overrides everything, including a held packet, which is discarded.
- FSM: IDLE (output register empty), FULL (out_valid=1, waiting on out_ready).
- can_load = enable && (state==IDLE || out_ready).
- Arbitration is combinational. The candidate set is req_valid. Search starts at rr pointer p and goes upward with wrap; the first set bit wins. req_ready[w] = can_load && req_valid[w]. All other req_ready bits are 0. req_ready never asserts without req_valid.
- On accept at clk edge: packet_reg.data <= increment(req_data[w]) (8-bit wrap, 8'hFF -> 8'h00), packet_reg.valid <= 1, out_src <= w, p <= (w+1) mod NUM_REQ, xfer_count <= xfer_count + 1 (wraps at 2^WIDTH). Next state is FULL.
- Latency: one cycle from input accept to out_valid.
- FULL, out_ready=1, and an accept in the same cycle: the new packet replaces the old one back-to-back. out_valid stays 1. Throughput is 1 transfer per cycle.
- FULL, out_ready=1, no accept: packet_reg.valid <= 0, go to IDLE. out_data and out_src hold their last values.
- FULL, out_ready=0: all outputs stable, req_ready all 0, p unchanged.
- enable=0: no accepts, p and xfer_count frozen. A packet in FULL still drains on out_ready.
- No requests: p unchanged.
- Fairness: any continuously valid requester is granted within NUM_REQ accepts.

Optional Feature:
PKT_SCHED_STATS_EN
- Defined: adds output grant_count (NUM_REQ*8). It holds one 8-bit counter per requester, incremented on each accept of that requester and saturating at 8'hFF. The counters clear on reset.
- Not defined: the port and counters are absent. All other behaviour is identical.

Decomposition:
- test_pkg: reuse data_packet_t and increment(). Add typedef sched_state_e {IDLE, FULL}.
- Sub-module rr_arbiter (params N; inputs req, ptr; outputs one-hot gnt, gnt_idx, any). It is purely combinational, using a double-width mask-and-priority scheme, and is reused by other shared-resource schedulers.

Test Plan:
- Reset: hold reset 2 cycles with all req_valid=1 -> out_valid=0, out_data=0, out_src=0, xfer_count=0, req_ready=0 during reset.
- Single requester: req_valid=4'b0100, data[2]=8'h41, out_ready=1 -> req_ready=4'b0100 in that cycle; next cycle out_valid=1, out_data=8'h42, out_src=2, xfer_count=1.
- Round-robin: all 4 valid continuously with data i=8'h10*i, out_ready=1 -> grants 0,1,2,3,0. out_data sequence 01,11,21,31,01, one per cycle; xfer_count=5.
- Backpressure: FULL with out_ready=0 for 3 cycles, all valid -> outputs stable, req_ready=0, pointer held. On out_ready=1, the next grant goes to the expected index.
- Wrap: data=8'hFF -> out_data=8'h00. Preload 2^WIDTH-1 transfers (or force WIDTH=4, 16 transfers) -> xfer_count wraps to 0.
- Enable/reset mid-operation: enable=0 while FULL with out_ready=1 -> drains to IDLE, no new grant. reset asserted while FULL -> out_valid=0 next cycle, packet lost, pointer back to 0.

Source files
------------

// File: rtl/test_pkg.sv
// Shared types and helpers for the packet datapath blocks: packet register
// layout, the byte increment function and the scheduler state encoding.
package test_pkg;

  localparam int PKG_WIDTH = 16;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
  } data_packet_t;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } sched_state_e;

  function automatic logic [7:0] increment(input logic [7:0] d);
    return d + 8'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the request vector is duplicated, bits
// below ptr in the low copy are masked, and the lowest surviving bit wins.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [2*N-1:0] w_mask;
  logic [2*N-1:0] w_dbl;

  always_comb begin
    w_mask  = '0;
    for (int i = 0; i < 2*N; i++) begin
      w_mask[i] = (i >= int'(ptr));
    end
    w_dbl   = {req, req} & w_mask;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    // Walk downward so the lowest set bit at or above ptr is the last written.
    for (int i = 2*N-1; i >= 0; i--) begin
      if (w_dbl[i]) begin
        any     = 1'b1;
        gnt_idx = IW'(i % N);
      end
    end
    gnt[gnt_idx] = any;
  end

endmodule

// File: rtl/packet_rr_scheduler.sv
// Round-robin scheduler sharing one increment datapath among NUM_REQ requesters.
// Define PKT_SCHED_STATS_EN to add saturating per-requester grant counters.
module packet_rr_scheduler
  import test_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = PKG_WIDTH,
  localparam int SRC_W  = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  output logic [SRC_W-1:0]     out_src,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     xfer_count
`ifdef PKT_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*8-1:0] grant_count
`endif
);

  sched_state_e       r_state, w_next_state;
  data_packet_t       r_pkt;
  logic [SRC_W-1:0]   r_src;
  logic [SRC_W-1:0]   r_ptr;
  logic [WIDTH-1:0]   r_xfer;

  logic [NUM_REQ-1:0] w_gnt;
  logic [SRC_W-1:0]   w_gnt_idx;
  logic               w_any;
  logic               w_can_load;
  logic               w_accept;
  logic [7:0]         w_sel_data;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  // A held packet may be replaced in the same cycle it is consumed.
  assign w_can_load = !reset && enable && (r_state == IDLE || out_ready);
  assign w_accept   = w_can_load && w_any;
  assign req_ready  = w_can_load ? w_gnt : '0;
  assign w_sel_data = req_data[{w_gnt_idx, 3'b000} +: 8];

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = FULL;
      FULL:    if (out_ready) w_next_state = w_accept ? FULL : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pkt   <= '0;
      r_src   <= '0;
      r_ptr   <= '0;
      r_xfer  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_pkt.valid <= 1'b1;
        r_pkt.data  <= increment(w_sel_data);
        r_src       <= w_gnt_idx;
        r_ptr       <= (w_gnt_idx == SRC_W'(NUM_REQ-1)) ? '0 : w_gnt_idx + 1'b1;
        r_xfer      <= r_xfer + 1'b1;
      end else if (r_state == FULL && out_ready) begin
        r_pkt.valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_pkt.valid;
  assign out_data   = r_pkt.data;
  assign out_src    = r_src;
  assign xfer_count = r_xfer;

`ifdef PKT_SCHED_STATS_EN
  logic [7:0] r_gcnt [NUM_REQ];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) r_gcnt[i] <= '0;
    end else if (w_accept && r_gcnt[w_gnt_idx] != 8'hFF) begin
      r_gcnt[w_gnt_idx] <= r_gcnt[w_gnt_idx] + 8'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_gcnt
    assign grant_count[8*g +: 8] = r_gcnt[g];
  end
`endif

endmodule

// File: tb/tb_packet_rr_scheduler.sv
// Directed bench for packet_rr_scheduler (4 requesters, 4-bit transfer counter
// so the counter wrap is reachable in a short run).
module tb_packet_rr_scheduler;
  import test_pkg::*;

  localparam int NREQ = 4;
  localparam int CW   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [7:0]        out_data;
  logic [1:0]        out_src;
  logic              out_ready;
  logic [CW-1:0]     xfer_count;
`ifdef PKT_SCHED_STATS_EN
  logic [NREQ*8-1:0] grant_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  packet_rr_scheduler #(.NUM_REQ(NREQ), .WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .xfer_count (xfer_count)
`ifdef PKT_SCHED_STATS_EN
    ,
    .grant_count(grant_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                           input logic [1:0] s, input logic [CW-1:0] x);
    check_eq({tag, ".valid"}, 32'(out_valid), 32'(v));
    check_eq({tag, ".data"},  32'(out_data),  32'(d));
    check_eq({tag, ".src"},   32'(out_src),   32'(s));
    check_eq({tag, ".xfer"},  32'(xfer_count), 32'(x));
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    out_ready = 1'b1;
    req_valid = 4'hF;
    req_data  = {8'h30, 8'h20, 8'h10, 8'h00};

    // Reset held for two cycles with every requester valid
    step();
    check_eq("rst_ready0", 32'(req_ready), 32'h0);
    step();
    check_eq("rst_ready1", 32'(req_ready), 32'h0);
    check_out("rst", 1'b0, 8'h00, 2'd0, 4'd0);

    reset     = 1'b0;
    req_valid = 4'b0000;
    #1;
    check_eq("idle_noreq_ready", 32'(req_ready), 32'h0);
    step();

    // Single requester 2
    req_valid = 4'b0100;
    req_data  = {8'h00, 8'h41, 8'h00, 8'h00};
    #1;
    check_eq("single_ready", 32'(req_ready), 32'b0100);
    step();
    check_out("single", 1'b1, 8'h42, 2'd2, 4'd1);
    req_valid = 4'b0000;
    step();
    check_out("single_drain", 1'b0, 8'h42, 2'd2, 4'd1);

    // Reset from idle to bring the pointer back to 0
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Round robin with every requester valid, one grant per cycle
    req_valid = 4'hF;
    req_data  = {8'h30, 8'h20, 8'h10, 8'h00};
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq($sformatf("rr_ready%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      step();
      check_out($sformatf("rr%0d", k), 1'b1, 8'(8'h10 * (k % 4) + 1), 2'(k % 4), 4'(k + 1));
    end

    // Backpressure: held packet stays put, no grants, pointer held at 1
    out_ready = 1'b0;
    #1;
    check_eq("bp_ready", 32'(req_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_out($sformatf("bp%0d", k), 1'b1, 8'h01, 2'd0, 4'd5);
      check_eq($sformatf("bp_ready%0d", k), 32'(req_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(req_ready), 32'b0010);
    step();
    check_out("bp_release", 1'b1, 8'h11, 2'd1, 4'd6);

    // Data wrap 0xFF -> 0x00, requester 2 alone
    req_valid = 4'b0100;
    req_data  = {8'h00, 8'hFF, 8'h00, 8'h00};
    #1;
    check_eq("wrap_ready", 32'(req_ready), 32'b0100);
    step();
    check_out("wrap", 1'b1, 8'h00, 2'd2, 4'd7);

    // Enable low while FULL: drains, no new grant, pointer frozen at 3
    enable    = 1'b0;
    req_valid = 4'hF;
    req_data  = {8'h30, 8'h20, 8'h10, 8'h00};
    #1;
    check_eq("en0_ready", 32'(req_ready), 32'h0);
    step();
    check_out("en0_drain", 1'b0, 8'h00, 2'd2, 4'd7);
    step();
    check_out("en0_hold", 1'b0, 8'h00, 2'd2, 4'd7);
    enable = 1'b1;
    #1;
    check_eq("en1_ready", 32'(req_ready), 32'b1000);
    step();
    check_out("en1", 1'b1, 8'h31, 2'd3, 4'd8);

    // Eight more accepts take the 4-bit counter from 8 through 16 -> 0
    for (int k = 0; k < 8; k++) step();
    check_out("xfer_wrap", 1'b1, 8'h31, 2'd3, 4'd0);

    // Reset while FULL discards the packet and rewinds the pointer
    out_ready = 1'b0;
    reset     = 1'b1;
    step();
    check_out("rst_full", 1'b0, 8'h00, 2'd0, 4'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    check_eq("rst_full_ptr", 32'(req_ready), 32'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
